// File: rtl/control_unit.sv
// Multi-cycle sequencer for the DataPath: fetch, PC increment, execute,
// memory operand access and ALU write-back, with a memory wait timeout.
// Optional feature macro: TRAP_ILLEGAL_EN (adds illegal_op and traps undefined
// opcodes into HALT; when undefined, unknown opcodes behave as NOP).
// Strobes are decoded from the state and, where a memory access completes,
// from mem_ready in the same cycle. Every output is forced low while reset
// is high.
module control_unit #(
  parameter int INST_SIZE    = 6,
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [INST_SIZE-1:0] opcode,
  input  logic                 alu_zero,
  input  logic                 alu_overflow,
  input  logic                 mem_ready,
  output logic                 ld_alu1,
  output logic                 ld_alu2,
  output logic                 ld_pc,
  output logic                 ld_acc,
  output logic                 ld_ir,
  output logic [1:0]           pc_src,
  output logic [2:0]           alu_operation,
  output logic [1:0]           alu1_src_mux_control,
  output logic [1:0]           alu2_src_mux_control,
  output logic [1:0]           acc_src_mux_control,
  output logic [1:0]           mem_data_select_control,
  output logic [1:0]           mem_addr_select_control,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 halted,
`ifdef TRAP_ILLEGAL_EN
  output logic                 illegal_op,
`endif
  output logic                 bus_error
);

  localparam logic [INST_SIZE-1:0] OP_NOP  = INST_SIZE'(0);
  localparam logic [INST_SIZE-1:0] OP_LDI  = INST_SIZE'(1);
  localparam logic [INST_SIZE-1:0] OP_LD   = INST_SIZE'(2);
  localparam logic [INST_SIZE-1:0] OP_ST   = INST_SIZE'(3);
  localparam logic [INST_SIZE-1:0] OP_ADD  = INST_SIZE'(4);
  localparam logic [INST_SIZE-1:0] OP_XOR  = INST_SIZE'(8);
  localparam logic [INST_SIZE-1:0] OP_JMP  = INST_SIZE'(9);
  localparam logic [INST_SIZE-1:0] OP_JZ   = INST_SIZE'(10);
  localparam logic [INST_SIZE-1:0] OP_JV   = INST_SIZE'(11);
  localparam logic [INST_SIZE-1:0] OP_JMPA = INST_SIZE'(12);
  localparam logic [INST_SIZE-1:0] OP_HLT  = INST_SIZE'(63);
  localparam logic [7:0]           WAIT_LIMIT = 8'(MEM_WAIT_MAX - 1);

  typedef enum logic [2:0] {FETCH, INCPC, EXEC, MEMOP, ALUWB, HALT} state_t;

  state_t     state;
  logic       z_flag;
  logic       v_flag;
  logic       bus_err_reg;
  logic [7:0] wait_cnt;
  logic       is_alu_op;
  logic       in_access;
  logic       timeout;

  // ADD..XOR occupy a contiguous opcode range; the ALU code is the offset.
  assign is_alu_op = (opcode >= OP_ADD) && (opcode <= OP_XOR);
  assign in_access = (state == FETCH) || (state == MEMOP);
  // wait_cnt holds the number of earlier wait cycles in this access, so this
  // cycle is the MEM_WAIT_MAX-th low cycle; a ready in this cycle still wins.
  assign timeout   = in_access && !mem_ready && (wait_cnt == WAIT_LIMIT);

`ifdef TRAP_ILLEGAL_EN
  logic illegal_reg;
  logic is_defined;
  assign is_defined = (opcode <= OP_JMPA) || (opcode == OP_HLT);
`endif

  // Sequencer state, latched ALU flags, wait counter and sticky error flags.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= FETCH;
      z_flag      <= 1'b0;
      v_flag      <= 1'b0;
      bus_err_reg <= 1'b0;
      wait_cnt    <= 8'd0;
`ifdef TRAP_ILLEGAL_EN
      illegal_reg <= 1'b0;
`endif
    end else begin
      wait_cnt <= (in_access && !mem_ready) ? wait_cnt + 8'd1 : 8'd0;
      case (state)
        FETCH: begin
          if (mem_ready) begin
            state <= INCPC;
          end else if (timeout) begin
            bus_err_reg <= 1'b1;
            state       <= HALT;
          end
        end
        INCPC: state <= EXEC;
        EXEC: begin
          state <= FETCH;
          if (opcode == OP_LD || opcode == OP_ST || is_alu_op) begin
            state <= MEMOP;
          end else if (opcode == OP_HLT) begin
            state <= HALT;
          end
`ifdef TRAP_ILLEGAL_EN
          else if (!is_defined) begin
            illegal_reg <= 1'b1;
            state       <= HALT;
          end
`endif
        end
        MEMOP: begin
          if (mem_ready) begin
            state <= is_alu_op ? ALUWB : FETCH;
          end else if (timeout) begin
            bus_err_reg <= 1'b1;
            state       <= HALT;
          end
        end
        ALUWB: begin
          z_flag <= alu_zero;
          v_flag <= alu_overflow;
          state  <= FETCH;
        end
        HALT:    state <= HALT;
        default: state <= FETCH;
      endcase
    end
  end

  // Output decode: state-driven controls plus completion strobes on mem_ready.
  always_comb begin
    ld_alu1                 = 1'b0;
    ld_alu2                 = 1'b0;
    ld_pc                   = 1'b0;
    ld_acc                  = 1'b0;
    ld_ir                   = 1'b0;
    pc_src                  = 2'd0;
    alu_operation           = 3'd0;
    alu1_src_mux_control    = 2'd0;
    alu2_src_mux_control    = 2'd0;
    acc_src_mux_control     = 2'd0;
    mem_data_select_control = 2'd0;
    mem_addr_select_control = 2'd0;
    mem_read                = 1'b0;
    mem_write               = 1'b0;
    halted                  = 1'b0;
    bus_error               = 1'b0;
`ifdef TRAP_ILLEGAL_EN
    illegal_op              = 1'b0;
`endif
    if (!reset) begin
      bus_error = bus_err_reg;
`ifdef TRAP_ILLEGAL_EN
      illegal_op = illegal_reg;
`endif
      case (state)
        FETCH: begin
          mem_addr_select_control = 2'd2;
          mem_read                = 1'b1;
          ld_ir                   = mem_ready;
        end
        INCPC: ld_pc = 1'b1;
        EXEC: begin
          case (opcode)
            OP_NOP: ;
            OP_LDI: begin
              ld_acc              = 1'b1;
              acc_src_mux_control = 2'd1;
            end
            OP_JMP: begin
              ld_pc  = 1'b1;
              pc_src = 2'd1;
            end
            OP_JZ: begin
              ld_pc  = z_flag;
              pc_src = z_flag ? 2'd1 : 2'd0;
            end
            OP_JV: begin
              ld_pc  = v_flag;
              pc_src = v_flag ? 2'd1 : 2'd0;
            end
            OP_JMPA: begin
              ld_pc  = 1'b1;
              pc_src = 2'd2;
            end
            default: ld_alu1 = is_alu_op;
          endcase
        end
        MEMOP: begin
          mem_addr_select_control = 2'd1;
          if (opcode == OP_ST) begin
            mem_write               = 1'b1;
            mem_data_select_control = 2'd1;
          end else begin
            mem_read = 1'b1;
            if (opcode == OP_LD) begin
              ld_acc              = mem_ready;
              acc_src_mux_control = mem_ready ? 2'd2 : 2'd0;
            end else begin
              ld_alu2              = mem_ready;
              alu2_src_mux_control = mem_ready ? 2'd2 : 2'd0;
            end
          end
        end
        ALUWB: begin
          ld_acc        = 1'b1;
          alu_operation = 3'(opcode - OP_ADD);
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit. For every instruction the bench builds
// the expected per-cycle output list from the instruction-level rules
// (fetch, pc increment, execute, memory operand, write-back), drives
// mem_ready to realise the chosen wait counts, and a negedge compare process
// checks each DUT cycle against that list. Directed programs add literal
// cycle-count expectations that pin the model.
module tb_control_unit;

  localparam int MAXW = 15;

  typedef struct packed {
    logic       ld_alu1;
    logic       ld_alu2;
    logic       ld_pc;
    logic       ld_acc;
    logic       ld_ir;
    logic [1:0] pc_src;
    logic [2:0] alu_op;
    logic [1:0] a1;
    logic [1:0] a2;
    logic [1:0] acc;
    logic [1:0] dsel;
    logic [1:0] asel;
    logic       mrd;
    logic       mwr;
    logic       halted;
    logic       berr;
    logic       illegal;
  } outv_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       alu_zero = 1'b0;
  logic       alu_overflow = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ld_alu1, ld_alu2, ld_pc, ld_acc, ld_ir;
  logic [1:0] pc_src;
  logic [2:0] alu_operation;
  logic [1:0] alu1_src_mux_control, alu2_src_mux_control, acc_src_mux_control;
  logic [1:0] mem_data_select_control, mem_addr_select_control;
  logic       mem_read, mem_write, halted, bus_error;
`ifdef TRAP_ILLEGAL_EN
  logic       illegal_op;
`endif

  control_unit #(.INST_SIZE(6), .MEM_WAIT_MAX(MAXW)) dut (
    .clock(clock), .reset(reset), .opcode(opcode),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .mem_ready(mem_ready),
    .ld_alu1(ld_alu1), .ld_alu2(ld_alu2), .ld_pc(ld_pc), .ld_acc(ld_acc), .ld_ir(ld_ir),
    .pc_src(pc_src), .alu_operation(alu_operation),
    .alu1_src_mux_control(alu1_src_mux_control),
    .alu2_src_mux_control(alu2_src_mux_control),
    .acc_src_mux_control(acc_src_mux_control),
    .mem_data_select_control(mem_data_select_control),
    .mem_addr_select_control(mem_addr_select_control),
    .mem_read(mem_read), .mem_write(mem_write), .halted(halted),
`ifdef TRAP_ILLEGAL_EN
    .illegal_op(illegal_op),
`endif
    .bus_error(bus_error)
  );

  always #5 clock = ~clock;

  outv_t      exp_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [5:0] ir = 6'd0;
  bit         mz = 0, mv = 0;
  bit         fix_flags = 0, fz = 0, fv = 0;

  // Observation counters, cleared while reset is high.
  int since_rst = 0, first_halt = 0, first_write = 0, first_berr = 0, first_rd = 0;
  int n_ld_ir = 0, n_ld_alu2 = 0, n_memop_rd = 0, n_jmp = 0, aluwb_op = 7;
  int ld_ir_c1 = 0, ld_ir_c2 = 0;

  function automatic outv_t dut_vec();
    outv_t a;
    a.ld_alu1 = ld_alu1;  a.ld_alu2 = ld_alu2;  a.ld_pc = ld_pc;
    a.ld_acc = ld_acc;    a.ld_ir = ld_ir;      a.pc_src = pc_src;
    a.alu_op = alu_operation;
    a.a1 = alu1_src_mux_control;  a.a2 = alu2_src_mux_control;
    a.acc = acc_src_mux_control;  a.dsel = mem_data_select_control;
    a.asel = mem_addr_select_control;
    a.mrd = mem_read;  a.mwr = mem_write;  a.halted = halted;  a.berr = bus_error;
`ifdef TRAP_ILLEGAL_EN
    a.illegal = illegal_op;
`else
    a.illegal = 1'b0;
`endif
    return a;
  endfunction

  // Compare process: one expected record per driven cycle.
  always @(negedge clock) begin
    outv_t e, a;
    a = dut_vec();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      vectors++;
      if (a !== e) begin
        miscompares++;
        $display("FAIL cycle_outputs t=%0t: got %07h expected %07h", $time, a, e);
      end
    end
    if (reset) begin
      since_rst = 0; first_halt = 0; first_write = 0; first_berr = 0; first_rd = 0;
      n_ld_ir = 0; n_ld_alu2 = 0; n_memop_rd = 0; n_jmp = 0; aluwb_op = 7;
      ld_ir_c1 = 0; ld_ir_c2 = 0;
    end else begin
      since_rst++;
      if (halted && first_halt == 0) first_halt = since_rst;
      if (mem_write && first_write == 0) first_write = since_rst;
      if (bus_error && first_berr == 0) first_berr = since_rst;
      if (mem_read && first_rd == 0) first_rd = since_rst;
      if (ld_ir) begin
        n_ld_ir++;
        if (ld_ir_c1 == 0) ld_ir_c1 = since_rst;
        else if (ld_ir_c2 == 0) ld_ir_c2 = since_rst;
      end
      if (ld_alu2) n_ld_alu2++;
      if (mem_read && mem_addr_select_control == 2'd1) n_memop_rd++;
      if (ld_pc && pc_src == 2'd1) n_jmp++;
      if (ld_acc && acc_src_mux_control == 2'd0) aluwb_op = int'(alu_operation);
    end
  end

  task automatic check(input string name, input int got, input int expv);
    vectors++;
    if (got != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, got, expv);
    end
  endtask

  task automatic cyc(input outv_t o, input logic rdy, input logic rst);
    @(posedge clock);
    #1;
    reset = rst;
    mem_ready = rdy;
    opcode = ir;
    alu_zero = fix_flags ? fz : 1'($urandom);
    alu_overflow = fix_flags ? fv : 1'($urandom);
    exp_q.push_back(o);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) cyc('0, 1'($urandom), 1'b1);
    mz = 0;
    mv = 0;
  endtask

  task automatic halt_cycles(input bit be, input bit il, input int n);
    outv_t o;
    o = '0;
    o.halted = 1'b1;
    o.berr = be;
    o.illegal = il;
    for (int i = 0; i < n; i++) cyc(o, 1'($urandom), 1'b0);
  endtask

  // kind: 0 instruction fetch, 1 LD, 2 ST, 3 ALU operand read
  task automatic access(input int kind, input int w, output bit ok);
    outv_t base, o;
    base = '0;
    base.asel = (kind == 0) ? 2'd2 : 2'd1;
    if (kind == 2) begin
      base.mwr = 1'b1;
      base.dsel = 2'd1;
    end else begin
      base.mrd = 1'b1;
    end
    ok = 1;
    for (int i = 0; i <= w; i++) begin
      o = base;
      if (i < w) begin
        cyc(o, 1'b0, 1'b0);
        if (i == MAXW - 1) begin
          ok = 0;
          return;
        end
      end else begin
        case (kind)
          0: o.ld_ir = 1'b1;
          1: begin o.ld_acc = 1'b1; o.acc = 2'd2; end
          3: begin o.ld_alu2 = 1'b1; o.a2 = 2'd2; end
          default: ;
        endcase
        cyc(o, 1'b1, 1'b0);
      end
    end
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm,
                           input bit rst_in_memop, output bit stopped);
    outv_t o;
    bit ok, illegal;
    int kind;
    stopped = 0;
    ir = 6'($urandom);
    access(0, wf, ok);
    if (!ok) begin
      halt_cycles(1, 0, 2);
      stopped = 1;
      return;
    end
    ir = op;
    o = '0;
    o.ld_pc = 1'b1;
    cyc(o, 1'($urandom), 1'b0);
    o = '0;
    kind = 0;
    illegal = (op > 6'd12) && (op != 6'd63);
    if (op == 6'd1) begin o.ld_acc = 1; o.acc = 2'd1; end
    else if (op == 6'd2) kind = 1;
    else if (op == 6'd3) kind = 2;
    else if (op >= 6'd4 && op <= 6'd8) begin kind = 3; o.ld_alu1 = 1; end
    else if (op == 6'd9 || (op == 6'd10 && mz) || (op == 6'd11 && mv)) begin
      o.ld_pc = 1; o.pc_src = 2'd1;
    end else if (op == 6'd12) begin o.ld_pc = 1; o.pc_src = 2'd2; end
    cyc(o, 1'($urandom), 1'b0);
    if (op == 6'd63) begin
      halt_cycles(0, 0, 2);
      stopped = 1;
      return;
    end
`ifdef TRAP_ILLEGAL_EN
    if (illegal) begin
      halt_cycles(0, 1, 2);
      stopped = 1;
      return;
    end
`endif
    if (kind != 0) begin
      if (rst_in_memop) begin
        cyc('0, 1'($urandom), 1'b1);
        mz = 0;
        mv = 0;
        return;
      end
      access(kind, wm, ok);
      if (!ok) begin
        halt_cycles(1, 0, 2);
        stopped = 1;
        return;
      end
      if (kind == 3) begin
        o = '0;
        o.ld_acc = 1;
        o.alu_op = 3'(op - 6'd4);
        cyc(o, 1'($urandom), 1'b0);
        mz = alu_zero;
        mv = alu_overflow;
      end
    end
  endtask

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return 0;
    if (r < 90) return $urandom_range(1, 3);
    if (r < 95) return MAXW - 1;
    return MAXW + $urandom_range(0, 3);
  endfunction

  function automatic logic [5:0] pick_op();
    int r;
    r = $urandom_range(0, 99);
    if (r < 4) return 6'd63;
    if (r < 9) return 6'($urandom_range(13, 62));
    return 6'($urandom_range(0, 12));
  endfunction

  task automatic settle();
    @(negedge clock);
    #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit st;
    // Program LDI 5; ST 10; HLT with zero-wait memory.
    do_reset(2);
    run_instr(6'd1, 0, 0, 0, st);
    run_instr(6'd3, 0, 0, 0, st);
    run_instr(6'd63, 0, 0, 0, st);
    settle();
    check("t1_write_cycle", first_write, 7);
    check("t1_halt_cycle", first_halt, 11);

    // ADD with three wait cycles on the operand read.
    do_reset(1);
    run_instr(6'd4, 0, 3, 0, st);
    settle();
    check("t2_memop_read_cycles", n_memop_rd, 4);
    check("t2_ld_alu2_pulses", n_ld_alu2, 1);
    check("t2_aluwb_op", aluwb_op, 0);

    // SUB sets Z, then JZ jumps; repeated with Z clear.
    fix_flags = 1; fz = 1; fv = 0;
    do_reset(1);
    run_instr(6'd5, 0, 0, 0, st);
    run_instr(6'd10, 0, 0, 0, st);
    settle();
    check("t3_jz_taken", n_jmp, 1);
    fz = 0;
    do_reset(1);
    run_instr(6'd5, 0, 0, 0, st);
    run_instr(6'd10, 0, 0, 0, st);
    settle();
    check("t3_jz_not_taken", n_jmp, 0);

    // Fetch never ready: timeout.
    do_reset(1);
    run_instr(6'd0, 40, 0, 0, st);
    settle();
    check("t4_bus_error_cycle", first_berr, MAXW + 1);
    check("t4_halt_cycle", first_halt, MAXW + 1);
    check("t4_ld_ir_pulses", n_ld_ir, 0);

    // Reset during ST memory phase clears latched Z.
    fz = 1;
    do_reset(1);
    run_instr(6'd5, 0, 0, 0, st);
    run_instr(6'd3, 0, 0, 1, st);
    run_instr(6'd10, 0, 0, 0, st);
    settle();
    check("t5_first_read_cycle", first_rd, 1);
    check("t5_jz_after_reset", n_jmp, 0);
    fix_flags = 0;

    // Undefined opcode 0x20.
    do_reset(1);
    run_instr(6'h20, 0, 0, 0, st);
`ifdef TRAP_ILLEGAL_EN
    settle();
    check("t6_trap_halt_cycle", first_halt, 4);
`else
    run_instr(6'd0, 0, 0, 0, st);
    settle();
    check("t6_first_fetch", ld_ir_c1, 1);
    check("t6_second_fetch", ld_ir_c2, 4);
`endif

    // Randomized instruction stream.
    do_reset(1);
    for (int n = 0; n < 400; n++) begin
      run_instr(pick_op(), pick_wait(), pick_wait(), ($urandom_range(0, 19) == 0), st);
      if (st) do_reset($urandom_range(1, 2));
    end

    settle();
    settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
